// File: rtl/spad_pkg.sv
// Shared types and constants for the SPAD shot sequencer: FSM states, hit record
// layout and the coarse clock period.
package spad_pkg;

  localparam int TW        = 10;  // coarse timestamp width
  localparam int IW        = 16;  // intensity word width
  localparam int HIT_SLOTS = 3;
  localparam int CLK_NS    = 4;   // clk_250M period

  typedef enum logic [2:0] {
    IDLE,
    START,
    WINDOW,
    REPORT,
    GAP
  } state_t;

  typedef struct packed {
    logic [TW-1:0] t;
    logic [IW-1:0] i;
  } hit_rec_t;

  // Converts a coarse tick count to nanoseconds.
  function automatic int cyc_to_ns(input int cyc);
    return cyc * CLK_NS;
  endfunction

endpackage

// File: rtl/spad_hit_capture.sv
// Photon gate edge detector and per-shot hit slot store. A slot holds the coarse
// timestamp and intensity of one rising gate edge; edges beyond the last slot set ovf.
module spad_hit_capture
  import spad_pkg::*;
#(
  parameter int MAX_HITS = HIT_SLOTS
) (
  input  logic                    clk_250M,
  input  logic                    rst_auto,
  input  logic                    clear,
  input  logic                    window_open,
  input  logic [TW-1:0]           tcnt,
  input  logic                    spad_gate,
  input  logic [IW-1:0]           spad_int,
  output logic [1:0]              hit_cnt,
  output logic [HIT_SLOTS*TW-1:0] hit_t,
  output logic [HIT_SLOTS*IW-1:0] hit_i,
  output logic                    ovf
);

  logic           r_gate_q;
  logic           w_edge;
  logic [1:0]     r_hit_cnt;
  logic           r_ovf;
  hit_rec_t       r_slot [HIT_SLOTS];

  // A gate held high for several cycles yields a single edge.
  assign w_edge = spad_gate & ~r_gate_q;

  // NOTE: sequential state uses <= so every flop samples pre-edge values,
  // independent of statement order inside the block.
  always_ff @(posedge clk_250M or posedge rst_auto) begin
    if (rst_auto) begin
      r_gate_q  <= 1'b0;
      r_hit_cnt <= 2'd0;
      r_ovf     <= 1'b0;
      // NOTE: the slots are a few flops, not a RAM, so they take the reset and read as zero.
      for (int k = 0; k < HIT_SLOTS; k++) r_slot[k] <= '0;
    end else begin
      r_gate_q <= spad_gate;
      if (clear) begin
        r_hit_cnt <= 2'd0;
        r_ovf     <= 1'b0;
        for (int k = 0; k < HIT_SLOTS; k++) r_slot[k] <= '0;
      end else if (window_open && w_edge) begin
        if (r_hit_cnt < 2'(MAX_HITS)) begin
          r_slot[r_hit_cnt] <= '{t: tcnt, i: spad_int};
          r_hit_cnt         <= r_hit_cnt + 2'd1;
        end else begin
          r_ovf <= 1'b1;
        end
      end
    end
  end

  for (genvar k = 0; k < HIT_SLOTS; k++) begin : g_pack
    assign hit_t[k*TW +: TW] = r_slot[k].t;
    assign hit_i[k*IW +: IW] = r_slot[k].i;
  end

  assign hit_cnt = r_hit_cnt;
  assign ovf     = r_ovf;

endmodule

// File: rtl/spad_shot_ctrl.sv
// Shot sequencer: fires tdc_start every PERIOD_CYC cycles, opens a WIN_CYC ranging
// window for hit capture, then reports the shot over a valid/ready handshake.
module spad_shot_ctrl
  import spad_pkg::*;
#(
  parameter int WIN_CYC    = 512,
  parameter int PERIOD_CYC = 1024,
  parameter int START_W    = 2,
  parameter int MAX_HITS   = HIT_SLOTS
) (
  input  logic                    clk_250M,
  input  logic                    rst_auto,
  input  logic                    en,
  output logic                    tdc_start,
  input  logic                    spad_gate,
  input  logic [IW-1:0]           spad_int,
  output logic                    shot_valid,
  input  logic                    shot_ready,
  output logic [1:0]              hit_cnt,
  output logic [HIT_SLOTS*TW-1:0] hit_t,
  output logic [HIT_SLOTS*IW-1:0] hit_i,
  output logic                    ovf,
  output logic                    late,
  output logic [15:0]             shot_id,
  output logic                    busy
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_begin;
  logic          w_window_open;
  logic          w_period_done;
  logic [TW-1:0] r_tcnt;
  logic [15:0]   r_pcnt;
  logic [15:0]   r_shot_id;
  logic          r_late;
  logic          r_tdc_start;
  logic          r_shot_valid;
  logic          r_busy;

  // tcnt is 0 in the first START cycle, so the window covers the start pulse too
  // and REPORT follows the tcnt = WIN_CYC-1 cycle.
  assign w_window_open = (r_state == START) || (r_state == WINDOW);
  assign w_period_done = (r_pcnt >= 16'(PERIOD_CYC - 1));

  // NOTE: every output of this block gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_begin     = 1'b0;
    case (r_state)
      IDLE: begin
        if (en) begin
          w_state_nxt = START;
          w_begin     = 1'b1;
        end
      end
      START: begin
        if (r_tcnt == TW'(START_W - 1)) w_state_nxt = WINDOW;
      end
      WINDOW: begin
        if (r_tcnt == TW'(WIN_CYC - 1)) w_state_nxt = REPORT;
      end
      REPORT: begin
        if (shot_ready) w_state_nxt = GAP;
      end
      GAP: begin
        if (!en) begin
          w_state_nxt = IDLE;
        end else if (w_period_done) begin
          w_state_nxt = START;
          w_begin     = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_250M or posedge rst_auto) begin
    if (rst_auto) begin
      r_state      <= IDLE;
      r_tcnt       <= '0;
      r_pcnt       <= '0;
      r_shot_id    <= '0;
      r_late       <= 1'b0;
      r_tdc_start  <= 1'b0;
      r_shot_valid <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (w_begin) begin
        r_tcnt <= '0;
        r_pcnt <= '0;
      end else begin
        if (w_window_open) r_tcnt <= r_tcnt + TW'(1);
        if ((r_state != IDLE) && (r_pcnt != 16'hFFFF)) r_pcnt <= r_pcnt + 16'd1;
      end

      if ((r_state == REPORT) && shot_ready) r_shot_id <= r_shot_id + 16'd1;

      // late is only re-evaluated when a GAP launches the next shot.
      if ((r_state == GAP) && en && w_period_done)
        r_late <= (r_pcnt > 16'(PERIOD_CYC - 1));

      // Registered from next state so the analog-facing outputs are glitch-free.
      r_tdc_start  <= (w_state_nxt == START);
      r_shot_valid <= (w_state_nxt == REPORT);
      r_busy       <= (w_state_nxt != IDLE);
    end
  end

  spad_hit_capture #(
    .MAX_HITS(MAX_HITS)
  ) u_hit_capture (
    .clk_250M   (clk_250M),
    .rst_auto   (rst_auto),
    .clear      (w_begin),
    .window_open(w_window_open),
    .tcnt       (r_tcnt),
    .spad_gate  (spad_gate),
    .spad_int   (spad_int),
    .hit_cnt    (hit_cnt),
    .hit_t      (hit_t),
    .hit_i      (hit_i),
    .ovf        (ovf)
  );

  assign tdc_start  = r_tdc_start;
  assign shot_valid = r_shot_valid;
  assign shot_id    = r_shot_id;
  assign late       = r_late;
  assign busy       = r_busy;

endmodule

// File: tb/tb_spad_shot_ctrl.sv
// Directed bench for spad_shot_ctrl: hit capture, overflow, window edges, report
// stall with late flag, enable release and mid-shot reset.
module tb_spad_shot_ctrl;

  logic        clk_250M = 1'b0;
  logic        rst_auto;
  logic        en;
  logic        tdc_start;
  logic        spad_gate;
  logic [15:0] spad_int;
  logic        shot_valid;
  logic        shot_ready;
  logic [1:0]  hit_cnt;
  logic [29:0] hit_t;
  logic [47:0] hit_i;
  logic        ovf;
  logic        late;
  logic [15:0] shot_id;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int s0     = 0;

  int          ev_t [5];
  logic [15:0] ev_i [5];
  int          ev_n;
  int          ev_w;

  spad_shot_ctrl dut (
    .clk_250M  (clk_250M),
    .rst_auto  (rst_auto),
    .en        (en),
    .tdc_start (tdc_start),
    .spad_gate (spad_gate),
    .spad_int  (spad_int),
    .shot_valid(shot_valid),
    .shot_ready(shot_ready),
    .hit_cnt   (hit_cnt),
    .hit_t     (hit_t),
    .hit_i     (hit_i),
    .ovf       (ovf),
    .late      (late),
    .shot_id   (shot_id),
    .busy      (busy)
  );

  always #2 clk_250M = ~clk_250M;
  always @(posedge clk_250M) cyc <= cyc + 1;

  task automatic set_ev(input int idx, input int t, input logic [15:0] iv);
    ev_t[idx] = t;
    ev_i[idx] = iv;
  endtask

  // Waits for a fresh tdc_start rise; s0 marks the first START cycle (tcnt = 0).
  task automatic wait_start(input string name, input int budget);
    logic prev;
    bit   found;
    prev  = tdc_start;
    found = 0;
    for (int k = 0; k < budget && !found; k++) begin
      @(negedge clk_250M);
      if (tdc_start && !prev) begin
        found = 1;
        s0    = cyc;
      end
      prev = tdc_start;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s: tdc_start rise not seen within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_valid(input string name, input int budget);
    bit found;
    found = 0;
    for (int k = 0; k < budget; k++) begin
      if (shot_valid) begin
        found = 1;
        break;
      end
      @(negedge clk_250M);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s: shot_valid not seen within %0d cycles", name, budget);
    end
  endtask

  // Drives the gate pattern from ev_* relative to s0 up to and including tcnt = stop_c.
  task automatic drive_until(input int stop_c);
    int c;
    c = cyc - s0;
    while (c <= stop_c) begin
      spad_gate = 1'b0;
      spad_int  = 16'h0;
      for (int i = 0; i < ev_n; i++) begin
        if (c >= ev_t[i] && c < ev_t[i] + ev_w) begin
          spad_gate = 1'b1;
          spad_int  = ev_i[i];
        end
      end
      @(negedge clk_250M);
      c = cyc - s0;
    end
    spad_gate = 1'b0;
    spad_int  = 16'h0;
  endtask

  task automatic test_reset();
    rst_auto   = 1'b1;
    en         = 1'b0;
    spad_gate  = 1'b0;
    spad_int   = 16'h0;
    shot_ready = 1'b1;
    repeat (3) @(negedge clk_250M);
    checks++;
    if ({tdc_start, shot_valid, hit_cnt, ovf, late, busy} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0", {tdc_start, shot_valid, hit_cnt, ovf, late, busy});
    end
    checks++;
    if ({hit_t, hit_i, shot_id} !== 94'b0) begin
      errors++;
      $display("FAIL reset_data: got t=%h i=%h id=%h expected 0", hit_t, hit_i, shot_id);
    end
    rst_auto = 1'b0;
    repeat (3) @(negedge clk_250M);
    checks++;
    if ({busy, tdc_start} !== 2'b00) begin
      errors++;
      $display("FAIL idle_en0: got busy=%b start=%b expected 0 0", busy, tdc_start);
    end
  endtask

  task automatic test_three_hits();
    int first;
    en = 1'b1;
    wait_start("t1_start", 5);
    first = s0;
    ev_n = 3; ev_w = 1;
    set_ev(0, 40, 16'h0007);
    set_ev(1, 200, 16'h0009);
    set_ev(2, 500, 16'h000B);
    drive_until(501);
    wait_valid("t1_valid", 50);
    checks++;
    if (hit_cnt !== 2'd3) begin errors++; $display("FAIL t1_hit_cnt: got %0d expected 3", hit_cnt); end
    checks++;
    if (hit_t !== {10'd500, 10'd200, 10'd40}) begin
      errors++; $display("FAIL t1_hit_t: got %h expected %h", hit_t, {10'd500, 10'd200, 10'd40});
    end
    checks++;
    if (hit_i !== {16'h000B, 16'h0009, 16'h0007}) begin
      errors++; $display("FAIL t1_hit_i: got %h expected 000b00090007", hit_i);
    end
    checks++;
    if ({ovf, late, shot_id} !== 18'd0) begin
      errors++; $display("FAIL t1_flags: got ovf=%b late=%b id=%0d expected 0 0 0", ovf, late, shot_id);
    end
    wait_start("t1_next_start", 1100);
    checks++;
    if (s0 - first !== 1024) begin
      errors++; $display("FAIL t1_period: got %0d expected 1024", s0 - first);
    end
  endtask

  // Uses the shot whose start was detected at the end of test_three_hits.
  task automatic test_overflow();
    ev_n = 5; ev_w = 1;
    set_ev(0, 10, 16'h0011);
    set_ev(1, 20, 16'h0012);
    set_ev(2, 30, 16'h0013);
    set_ev(3, 40, 16'h0014);
    set_ev(4, 50, 16'h0015);
    drive_until(51);
    wait_valid("t2_valid", 600);
    checks++;
    if (hit_t !== {10'd30, 10'd20, 10'd10}) begin
      errors++; $display("FAIL t2_hit_t: got %h expected %h", hit_t, {10'd30, 10'd20, 10'd10});
    end
    checks++;
    if (hit_i !== {16'h0013, 16'h0012, 16'h0011}) begin
      errors++; $display("FAIL t2_hit_i: got %h expected 001300120011", hit_i);
    end
    checks++;
    if ({hit_cnt, ovf} !== 3'b111) begin
      errors++; $display("FAIL t2_cnt_ovf: got cnt=%0d ovf=%b expected 3 1", hit_cnt, ovf);
    end
    checks++;
    if (shot_id !== 16'd1) begin errors++; $display("FAIL t2_shot_id: got %0d expected 1", shot_id); end
  endtask

  task automatic test_empty_and_wide();
    wait_start("t3_start", 1100);
    ev_n = 0;
    wait_valid("t3_valid", 600);
    checks++;
    if ({hit_cnt, ovf, hit_t} !== 33'd0) begin
      errors++; $display("FAIL t3_empty: got cnt=%0d ovf=%b t=%h expected 0", hit_cnt, ovf, hit_t);
    end
    @(negedge clk_250M);
    checks++;
    if (shot_valid !== 1'b0) begin errors++; $display("FAIL t3_valid_pulse: got %b expected 0", shot_valid); end

    wait_start("t3b_start", 1100);
    ev_n = 1; ev_w = 4;
    set_ev(0, 100, 16'h0055);
    drive_until(104);
    wait_valid("t3b_valid", 600);
    checks++;
    if ({hit_cnt, hit_t} !== {2'd1, 20'd0, 10'd100}) begin
      errors++; $display("FAIL t3b_wide: got cnt=%0d t=%h expected 1 %h", hit_cnt, hit_t, {20'd0, 10'd100});
    end
    checks++;
    if (hit_i !== {32'd0, 16'h0055}) begin errors++; $display("FAIL t3b_int: got %h expected 55", hit_i); end
  endtask

  task automatic test_window_edges();
    wait_start("t4_start", 1100);
    ev_n = 1; ev_w = 1;
    set_ev(0, 511, 16'h00AA);
    drive_until(511);
    wait_valid("t4_valid", 10);
    checks++;
    if ({hit_cnt, hit_t[9:0], hit_i[15:0]} !== {2'd1, 10'd511, 16'h00AA}) begin
      errors++; $display("FAIL t4_last_cycle: got cnt=%0d t=%0d i=%h expected 1 511 aa", hit_cnt, hit_t[9:0], hit_i[15:0]);
    end

    wait_start("t4b_start", 1100);
    ev_n = 2; ev_w = 1;
    set_ev(0, 300, 16'h0030);
    set_ev(1, 512, 16'h0040);
    drive_until(514);
    checks++;
    if ({hit_cnt, hit_t, hit_i} !== {2'd1, 20'd0, 10'd300, 32'd0, 16'h0030}) begin
      errors++; $display("FAIL t4_after_window: got cnt=%0d t=%h i=%h expected 1 300 30", hit_cnt, hit_t, hit_i);
    end
    checks++;
    if (shot_id !== 16'd6) begin errors++; $display("FAIL t4_shot_id: got %0d expected 6", shot_id); end
  endtask

  task automatic test_stall_and_en_release();
    logic [95:0] snap;
    bit          stable;
    bit          rose;
    shot_ready = 1'b0;
    wait_start("t5_start", 1100);
    ev_n = 1; ev_w = 1;
    set_ev(0, 60, 16'h0066);
    drive_until(61);
    wait_valid("t5_valid", 600);
    snap   = {hit_cnt, hit_t, hit_i, ovf, shot_id};
    stable = 1;
    repeat (600) begin
      @(negedge clk_250M);
      if ({hit_cnt, hit_t, hit_i, ovf, shot_id} !== snap || !shot_valid) stable = 0;
    end
    checks++;
    if (!stable) begin errors++; $display("FAIL t5_hold: got unstable report expected stable for 600 cycles"); end
    checks++;
    if (snap !== {2'd1, 20'd0, 10'd60, 32'd0, 16'h0066, 1'b0, 16'd6}) begin
      errors++; $display("FAIL t5_report: got %h expected t=60 i=66 id=6", snap);
    end
    shot_ready = 1'b1;
    wait_start("t5_restart", 4);
    checks++;
    if ({late, shot_id} !== {1'b1, 16'd7}) begin
      errors++; $display("FAIL t5_late: got late=%b id=%0d expected 1 7", late, shot_id);
    end

    ev_n = 0;
    drive_until(100);
    en = 1'b0;
    wait_valid("t5_en_valid", 600);
    checks++;
    if ({hit_cnt, shot_id} !== {2'd0, 16'd7}) begin
      errors++; $display("FAIL t5_en_report: got cnt=%0d id=%0d expected 0 7", hit_cnt, shot_id);
    end
    repeat (3) @(negedge clk_250M);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL t5_idle_busy: got %b expected 0", busy); end
    rose = 0;
    repeat (1100) begin
      @(negedge clk_250M);
      if (tdc_start || busy) rose = 1;
    end
    checks++;
    if (rose) begin errors++; $display("FAIL t5_stays_idle: got activity expected none"); end
  endtask

  task automatic test_mid_shot_reset();
    en = 1'b1;
    wait_start("t6_start", 5);
    ev_n = 1; ev_w = 1;
    set_ev(0, 50, 16'h0077);
    drive_until(299);
    checks++;
    if ({hit_cnt, busy, late, shot_id} !== {2'd1, 1'b1, 1'b1, 16'd8}) begin
      errors++; $display("FAIL t6_pre_reset: got cnt=%0d busy=%b late=%b id=%0d expected 1 1 1 8", hit_cnt, busy, late, shot_id);
    end
    rst_auto = 1'b1;
    #1;
    checks++;
    if ({tdc_start, shot_valid, hit_cnt, hit_t, hit_i, ovf, late, shot_id, busy} !== 101'b0) begin
      errors++; $display("FAIL t6_async_clear: got cnt=%0d t=%h i=%h late=%b id=%0d busy=%b expected all 0", hit_cnt, hit_t, hit_i, late, shot_id, busy);
    end
    repeat (2) @(negedge clk_250M);
    rst_auto = 1'b0;
    @(negedge clk_250M);
    checks++;
    if ({tdc_start, busy, shot_id, late} !== {1'b1, 1'b1, 16'd0, 1'b0}) begin
      errors++; $display("FAIL t6_restart: got start=%b busy=%b id=%0d late=%b expected 1 1 0 0", tdc_start, busy, shot_id, late);
    end
  endtask

  initial begin
    test_reset();
    test_three_hits();
    test_overflow();
    test_empty_and_wide();
    test_window_edges();
    test_stall_and_en_release();
    test_mid_shot_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
